tisaradc_cal_ctrl: RTL
======================

Name: tisaradc_cal_ctrl

Overview:
Foreground offset-calibration sequencer for the 8-way, 9-bit time-interleaved SAR ADC. On start it pulses the ADC clock-generator reset, waits for the clocks to settle, then runs an 8-step successive-approximation search on each way's comparator offset trim. The search uses averaged output codes taken while the ADC input is shorted. It sits between the control register file and the TISARADC trim pins (osp*/osm*, clkrst) and consumes the deserialized adcout words.

Parameters:
ADC_WAYS, 8, number of interleaved sub-ADCs
ADC_BITS, 9, sub-ADC output width (offset binary, midcode 2^(ADC_BITS-1))
TRIM_BITS, 8, offset trim code width per way
AVG_LOG2, 4, log2 of samples averaged per decision (16)
RST_CYCLES, 8, clkrst pulse length in clocks
WARM_CYCLES, 64, clocks to wait after clkrst release
SETTLE_CYCLES, 4, clocks ignored after each trim change

Ports:
clock  in  1  single clock (deserializer domain)
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; starts calibration when idle
abort  in  1  level; returns to IDLE, trims hold current values
adc_valid  in  1  adc_data holds a new sample from every way
adc_data  in  ADC_WAYS*ADC_BITS  way w at bits [w*ADC_BITS +: ADC_BITS]
sw_override  in  1  drive sw_code to all ways instead of cal result
sw_code  in  TRIM_BITS*ADC_WAYS  manual trim codes, packed like adc_data
osp  out  TRIM_BITS*ADC_WAYS  positive trim per way = code
osm  out  TRIM_BITS*ADC_WAYS  negative trim per way = ~code
clkrst  out  1  ADC clock-generator reset
busy  out  1  calibration in progress
done  out  1  sticky; set on completion, cleared by start
sat  out  ADC_WAYS  final code of way w is 0 or all-ones

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; every code=0x80, so osp=0x80 and osm=0x7F; clkrst=0; busy=0; done=0; sat=0.
- States:
  - IDLE: start -> CLKRST.
  - CLKRST: clkrst=1 for RST_CYCLES clocks -> WARMUP.
  - WARMUP: WARM_CYCLES clocks -> LOAD with way=0.
  - LOAD: code[way]=0x80, bit=TRIM_BITS-1 -> SETTLE.
  - SETTLE: SETTLE_CYCLES clocks -> ACCUM.
  - ACCUM: accumulate data of current way on each adc_valid cycle until 2^AVG_LOG2 samples are taken -> DECIDE.
  - DECIDE (1 clock): resolve the current bit -> SETTLE or NEXT.
  - NEXT: way==ADC_WAYS-1 -> DONE, else way+1 -> LOAD.
  - DONE (1 clock): done=1 -> IDLE.
- busy=1 in every state except IDLE.
- clkrst is registered; asserts the cycle after start is sampled.
- The accumulator is ADC_BITS+AVG_LOG2 bits, unsigned, cleared on entry to ACCUM; no overflow is possible.
- DECIDE rule: if sum > (2^(ADC_BITS-1) << AVG_LOG2) the tested bit is cleared, else it is kept. Equality keeps the bit.
  - If bit>0: set bit-1 of code, bit-1 -> SETTLE.
  - If bit==0: -> NEXT.
- sat[w] is updated when way w leaves DECIDE at bit 0; it is cleared for all ways on start.
- Codes of ways not under calibration hold their value. Ways not yet reached hold their previous result.
- sw_override=1: osp/osm driven from sw_code combinationally. The internal search still runs and its results are kept.
- Output latency: osp/osm change 1 clock after code updates (registered codes, combinational mux).
- start while busy: ignored.
- abort: takes priority over every transition, including a simultaneous start in IDLE. Next state is IDLE; clkrst=0; busy=0; done stays 0. The in-flight way keeps its partial code.
- adc_valid low during ACCUM: accumulation stalls indefinitely; no timeout.
- Total time with continuous adc_valid: RST+WARM+1 + ADC_WAYS*(1 + TRIM_BITS*(SETTLE+16+1)) + ADC_WAYS + 1 clocks.

Decomposition:
- Shared package tisaradc_pkg: ADC_WAYS, ADC_BITS, TRIM_BITS, midcode constant, state enum type.
- One sub-module, tisaradc_cal_accum: sample counter, sum register, and the compare-against-midcode decision output.

Test Plan:
- Reset then idle for 100 clocks -> every osp byte 0x80, osm 0x7F, clkrst/busy/done 0.
- Constant adc_data=256 on all ways, adc_valid=1, start -> clkrst high exactly 8 clocks. Every bit is kept (equality), so all codes are 0xFF, sat=0xFF, done=1. Completion at the computed cycle count: 8+64+1+8*(1+8*21)+8+1 = 1434.
- Behavioural model where way w output = 256 + (code-0x80) - (10*w-35) -> way w converges to 0x80+10*w-35 (way0 0x5D, way7 0xA3), sat=0.
- Start, toggle adc_valid 1-of-3 cycles -> identical codes to the continuous case; ACCUM duration triples.
- Assert abort during way 3 ACCUM -> IDLE next clock; ways 0-2 retain results, busy=0, done=0. A following start completes normally.
- sw_override=1 with sw_code all 0x11 -> osp=0x11 and osm=0xEE on every way. Deasserting sw_override restores the calibrated codes.

Source files
------------

// File: rtl/tisaradc_pkg.sv
// Shared constants and FSM state type for the TISARADC offset-calibration sequencer.
package tisaradc_pkg;
    localparam int ADC_WAYS      = 8;
    localparam int ADC_BITS      = 9;
    localparam int TRIM_BITS     = 8;
    localparam int AVG_LOG2      = 4;
    localparam int RST_CYCLES    = 8;
    localparam int WARM_CYCLES   = 64;
    localparam int SETTLE_CYCLES = 4;

    localparam int WAY_W = $clog2(ADC_WAYS);
    localparam int BIT_W = $clog2(TRIM_BITS);
    localparam int CNT_W = 8;
    localparam int SUM_W = ADC_BITS + AVG_LOG2;

    localparam logic [TRIM_BITS-1:0] CODE_MID = TRIM_BITS'(1) << (TRIM_BITS - 1);
    // Midcode scaled by the averaging depth, so the sum is compared without a divide.
    localparam logic [SUM_W-1:0]     SUM_THR  = SUM_W'(1) << (ADC_BITS - 1 + AVG_LOG2);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLKRST,
        ST_WARMUP,
        ST_LOAD,
        ST_SETTLE,
        ST_ACCUM,
        ST_DECIDE,
        ST_NEXT,
        ST_DONE
    } cal_state_e;
endpackage

// File: rtl/tisaradc_cal_ctrl_if.sv
// Control/data bundle between the register file, deserializer and the calibration sequencer.
interface tisaradc_cal_ctrl_if;
    import tisaradc_pkg::*;

    logic                               start;
    logic                               abort;
    logic                               adc_valid;
    logic [ADC_WAYS-1:0][ADC_BITS-1:0]  adc_data;
    logic                               sw_override;
    logic [ADC_WAYS-1:0][TRIM_BITS-1:0] sw_code;
    logic [ADC_WAYS-1:0][TRIM_BITS-1:0] osp;
    logic [ADC_WAYS-1:0][TRIM_BITS-1:0] osm;
    logic                               clkrst;
    logic                               busy;
    logic                               done;
    logic [ADC_WAYS-1:0]                sat;

    modport master (
        output start, abort, adc_valid, adc_data, sw_override, sw_code,
        input  osp, osm, clkrst, busy, done, sat
    );

    modport slave (
        input  start, abort, adc_valid, adc_data, sw_override, sw_code,
        output osp, osm, clkrst, busy, done, sat
    );
endinterface

// File: rtl/tisaradc_cal_accum.sv
// Sample counter and running sum for one averaged decision; flags sum above the scaled midcode.
module tisaradc_cal_accum
    import tisaradc_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [ADC_BITS-1:0] sample_i,
    output logic                last_o,
    output logic                gt_o
);
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;

    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clr_i) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + AVG_LOG2'(1);
            sum_d = sum_q + SUM_W'(sample_i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    assign last_o = en_i && (cnt_q == '1);
    assign gt_o   = sum_q > SUM_THR;
endmodule

// File: rtl/tisaradc_cal_ctrl.sv
// Foreground offset-calibration sequencer: clkrst pulse, warm-up, then per-way SAR search on the trim code.
module tisaradc_cal_ctrl
    import tisaradc_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    tisaradc_cal_ctrl_if.slave bus
);
    cal_state_e                         state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [WAY_W-1:0]                   way_q, way_d;
    logic [BIT_W-1:0]                   bit_q, bit_d;
    logic [ADC_WAYS-1:0][TRIM_BITS-1:0] code_q, code_d;
    logic [ADC_WAYS-1:0]                sat_q, sat_d;
    logic                               done_q, done_d;
    logic                               clkrst_q;
    logic [TRIM_BITS-1:0]               trial;
    logic                               acc_last, acc_gt;

    tisaradc_cal_accum u_accum (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (state_q == ST_SETTLE),
        .en_i     ((state_q == ST_ACCUM) && bus.adc_valid),
        .sample_i (bus.adc_data[way_q]),
        .last_o   (acc_last),
        .gt_o     (acc_gt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        bit_d   = bit_q;
        code_d  = code_q;
        sat_d   = sat_q;
        done_d  = done_q;
        trial   = code_q[way_q];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLKRST;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    sat_d   = '0;
                end
            end
            ST_CLKRST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
            end
            ST_WARMUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WARM_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                    way_d   = '0;
                end
            end
            ST_LOAD: begin
                code_d[way_q] = CODE_MID;
                bit_d         = BIT_W'(TRIM_BITS - 1);
                cnt_d         = '0;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (acc_last) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                // Output above midcode means the trim overshoots: drop the bit under test.
                if (acc_gt) trial[bit_q] = 1'b0;
                if (bit_q != '0) begin
                    trial[bit_q - BIT_W'(1)] = 1'b1;
                    bit_d   = bit_q - BIT_W'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    sat_d[way_q] = (trial == '0) || (trial == '1);
                    state_d      = ST_NEXT;
                end
                code_d[way_q] = trial;
            end
            ST_NEXT: begin
                if (way_q == WAY_W'(ADC_WAYS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    way_d   = way_q + WAY_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort freezes all results where they stand, including a start seen the same cycle.
        if (bus.abort) begin
            state_d = ST_IDLE;
            code_d  = code_q;
            sat_d   = sat_q;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            way_q    <= '0;
            bit_q    <= '0;
            code_q   <= {ADC_WAYS{CODE_MID}};
            sat_q    <= '0;
            done_q   <= 1'b0;
            clkrst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            way_q    <= way_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            clkrst_q <= (state_d == ST_CLKRST);
        end
    end

    for (genvar w = 0; w < ADC_WAYS; w++) begin : g_way
        logic [TRIM_BITS-1:0] lane_code;
        assign lane_code   = bus.sw_override ? bus.sw_code[w] : code_q[w];
        assign bus.osp[w]  = lane_code;
        assign bus.osm[w]  = ~lane_code;
    end

    assign bus.clkrst = clkrst_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.sat    = sat_q;
endmodule
